// File: rtl/kbd_mmio_port.sv
// -----------------------------------------------------------------------------
// kbd_mmio_port
//   Keyboard input peripheral for the single-cycle MIPS CPU.
//   - Receives PS/2-style frames (start, 8 data bits LSB first, odd parity,
//     stop) on ps2_clk/ps2_data. Both lines are asynchronous to clk and pass
//     through 2-flop synchronisers.
//   - Buffers the received scan bytes in a small FIFO.
//   - Presents two read-only words to CPU loads through a combinational read
//     port:
//       ADDR_STATUS : {28'b0, parity_err, overflow, full, !empty}
//                     Reading it clears overflow and parity_err.
//       ADDR_DATA   : {24'b0, head byte}. Reading it pops the FIFO; when the
//                     FIFO is empty it returns 0 and nothing moves.
//
// Ports
//   clk          in   1   system clock, all state on posedge
//   reset        in   1   asynchronous, active-high reset
//   ps2_clk      in   1   keyboard serial clock (async)
//   ps2_data     in   1   keyboard serial data (async)
//   cpu_addr     in   32  CPU load byte address
//   cpu_rd_en    in   1   CPU load strobe, one clk per lw
//   cpu_rd_data  out  32  read word, 0 when cpu_rd_hit=0
//   cpu_rd_hit   out  1   load addresses STATUS or DATA (combinational)
//   irq          out  1   FIFO non-empty
//   overflow     out  1   sticky: a byte was dropped because the FIFO was full
//
// Configuration macro
//   KBD_PARITY_CHECK_EN : when defined, the parity bit is checked. A frame
//   with bad parity is discarded at its stop bit and parity_err (STATUS[3]) is
//   set. When the macro is undefined, the parity bit is sampled and ignored,
//   and STATUS[3] always reads 0.
// -----------------------------------------------------------------------------
module kbd_mmio_port #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] ADDR_STATUS = 32'h0000_4000,
   parameter logic [31:0] ADDR_DATA   = 32'h0000_4004,
   parameter int          TIMEOUT     = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_rd_en,
   output logic [31:0] cpu_rd_data,
   output logic        cpu_rd_hit,
   output logic        irq,
   output logic        overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   // ------------------------------------------------------------------
   // Synchronisers. The clock and data lines have the same depth, so the
   // synced data is aligned with the detected falling edge. Everything
   // resets to 1 (the idle level of the bus), so reset can never produce a
   // spurious falling edge.
   // ------------------------------------------------------------------
   logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
   logic ps2_data_meta_q, ps2_data_sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps2_clk_meta_q  <= 1'b1;
         ps2_clk_sync_q  <= 1'b1;
         ps2_clk_prev_q  <= 1'b1;
         ps2_data_meta_q <= 1'b1;
         ps2_data_sync_q <= 1'b1;
      end else begin
         ps2_clk_meta_q  <= ps2_clk;
         ps2_clk_sync_q  <= ps2_clk_meta_q;
         ps2_clk_prev_q  <= ps2_clk_sync_q;
         ps2_data_meta_q <= ps2_data;
         ps2_data_sync_q <= ps2_data_meta_q;
      end
   end

   logic ps2_fall;
   logic data_s;
   assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q;
   assign data_s   = ps2_data_sync_q;

   // ------------------------------------------------------------------
   // Frame receiver FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_bad_q, parity_bad_d;
   logic [TO_W-1:0] timer_q, timer_d;
   logic            push_req;     // a complete, valid byte sits in shift_q
   logic            frame_perr;   // a frame ended with a parity mismatch

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         parity_bad_q <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_bad_q <= parity_bad_d;
         timer_q      <= timer_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_bad_d = parity_bad_q;
      push_req     = 1'b0;
      frame_perr   = 1'b0;

      // The timer counts clk cycles since the last falling edge, and only
      // while a frame is in progress.
      if (state_q == ST_IDLE || ps2_fall) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // A high start bit is line noise, so we stay idle.
            if (ps2_fall && !data_s) begin
               state_d      = ST_DATA;
               bit_cnt_d    = 3'd0;
               parity_bad_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (ps2_fall) begin
               // The byte arrives LSB first, so shift right from the top.
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (ps2_fall) begin
`ifdef KBD_PARITY_CHECK_EN
               // Odd parity: data bits plus the parity bit must hold an odd
               // number of ones.
               parity_bad_d = ~(^shift_q ^ data_s);
`endif
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (ps2_fall) begin
               state_d = ST_IDLE;
               if (parity_bad_q) begin
                  frame_perr = 1'b1;
               end else if (data_s) begin
                  push_req = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An abandoned frame returns the receiver to IDLE so the next start bit
      // is framed correctly.
      if (state_q != ST_IDLE && !ps2_fall && timer_q == TO_W'(TIMEOUT - 1)) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end
   end

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic sel_status, sel_data;
   logic status_rd, data_rd;

   assign sel_status = (cpu_addr == ADDR_STATUS);
   assign sel_data   = (cpu_addr == ADDR_DATA);
   assign status_rd  = cpu_rd_en & sel_status;
   assign data_rd    = cpu_rd_en & sel_data;

   // ------------------------------------------------------------------
   // Scan-byte FIFO
   // ------------------------------------------------------------------
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             parity_err_q, parity_err_d;
   logic             empty, full;
   logic             push, pop, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop   = data_rd & ~empty;
   // When full, a same-cycle pop frees the slot the push needs.
   assign push  = push_req & (~full | pop);
   assign drop  = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // A sticky flag being set in the same cycle it is read wins over the
      // clear.
      overflow_d   = drop       | (overflow_q   & ~status_rd);
      parity_err_d = frame_perr | (parity_err_q & ~status_rd);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
      end
   end

   // The storage needs no reset because the pointers and count define which
   // entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   // ------------------------------------------------------------------
   // Read port. It is combinational because the single-cycle CPU consumes
   // the load data in the same cycle.
   // ------------------------------------------------------------------
   logic [31:0] status_word, data_word;

   assign status_word = {28'd0, parity_err_q, overflow_q, full, ~empty};
   assign data_word   = {24'd0, (empty ? 8'h00 : mem[rd_ptr_q])};
   assign cpu_rd_hit  = cpu_rd_en & (sel_status | sel_data);
   assign cpu_rd_data = !cpu_rd_hit ? 32'd0 : (sel_status ? status_word : data_word);
   assign irq         = ~empty;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_kbd_mmio_port.sv
// -----------------------------------------------------------------------------
// tb_kbd_mmio_port
//   Self-checking bench for kbd_mmio_port. A reference model keeps the
//   received bytes in a queue and holds the two sticky flags. A frame is judged
//   from its bits alone (stop level, parity), and each CPU read is predicted
//   from the queue contents and the flags.
// -----------------------------------------------------------------------------
module tb_kbd_mmio_port;

   localparam logic [31:0] A_STATUS = 32'h0000_4000;
   localparam logic [31:0] A_DATA   = 32'h0000_4004;
   localparam int          DEPTH    = 4;
`ifdef KBD_PARITY_CHECK_EN
   localparam bit PARCHK = 1'b1;
`else
   localparam bit PARCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] cpu_addr = 32'd0;
   logic        cpu_rd_en = 1'b0;
   logic [31:0] cpu_rd_data;
   logic        cpu_rd_hit;
   logic        irq;
   logic        overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model
   logic [7:0] model_q[$];
   bit         model_ovf;
   bit         model_perr;

   kbd_mmio_port dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .cpu_addr    (cpu_addr),
      .cpu_rd_en   (cpu_rd_en),
      .cpu_rd_data (cpu_rd_data),
      .cpu_rd_hit  (cpu_rd_hit),
      .irq         (irq),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Drive the first nbits bits of a frame. Each bit is 20 clk long.
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit stop_val,
                            input int nbits);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = ~(^b) ^ bad_par;
      bits[10]  = stop_val;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (10) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (10) @(posedge clk);
         ps2_clk = 1'b1;
      end
      repeat (10) @(posedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit stop_val);
      if (PARCHK && bad_par) begin
         model_perr = 1'b1;
      end else if (stop_val) begin
         if (model_q.size() == DEPTH) model_ovf = 1'b1;
         else model_q.push_back(b);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_val);
      send_bits(b, bad_par, stop_val, 11);
      model_frame(b, bad_par, stop_val);
   endtask

   task automatic read_reg(input logic [31:0] addr, output logic [31:0] data, output logic hit);
      @(negedge clk);
      cpu_addr  = addr;
      cpu_rd_en = 1'b1;
      #1;
      data = cpu_rd_data;
      hit  = cpu_rd_hit;
      @(negedge clk);
      cpu_rd_en = 1'b0;
      cpu_addr  = 32'd0;
   endtask

   task automatic do_status(output logic [31:0] act, output logic [31:0] exp);
      logic hit;
      exp = {28'd0, model_perr, model_ovf, (model_q.size() == DEPTH), (model_q.size() != 0)};
      read_reg(A_STATUS, act, hit);
      model_ovf  = 1'b0;
      model_perr = 1'b0;
   endtask

   task automatic do_data(output logic [31:0] act, output logic [31:0] exp);
      logic hit;
      if (model_q.size() != 0) exp = {24'd0, model_q.pop_front()};
      else exp = 32'd0;
      read_reg(A_DATA, act, hit);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      model_q.delete();
      model_ovf  = 1'b0;
      model_perr = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] act, exp;
      logic hit;
      apply_reset();
      #1;
      tests_run++;
      if ({irq, overflow, cpu_rd_hit, cpu_rd_data} !== 35'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got irq=%b ovf=%b hit=%b data=%h want all 0",
                  irq, overflow, cpu_rd_hit, cpu_rd_data);
      end
      @(negedge clk);
      reset = 1'b0;
      read_reg(A_STATUS, act, hit);
      exp = 32'd0;
      tests_run++;
      if (act !== exp || hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_status: got %h hit=%b want %h hit=1", act, hit, exp);
      end
   endtask

   task automatic test_single();
      logic [31:0] act, exp;
      send_frame(8'h1C, 1'b0, 1'b1);
      tests_run++;
      if (irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_irq: got %b want 1", irq);
      end
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL single_status: got %h want %h", act, exp);
      end
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL single_data: got %h want %h", act, exp);
      end
      do_status(act, exp);
      tests_run++;
      if (act !== exp || irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_after: got %h irq=%b want %h irq=0", act, irq, exp);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] act, exp;
      for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1);
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_pin: got %b want 1", overflow);
      end
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL ovf_status: got %h want %h", act, exp);
      end
      for (int i = 0; i < 4; i++) begin
         do_data(act, exp);
         tests_run++;
         if (act !== exp) begin
            tests_failed++;
            $display("FAIL ovf_data%0d: got %h want %h", i, act, exp);
         end
      end
      do_status(act, exp);
      tests_run++;
      if (act !== exp || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_cleared: got %h ovf=%b want %h ovf=0", act, overflow, exp);
      end
   endtask

   task automatic test_bad_stop();
      logic [31:0] act, exp;
      send_frame(8'h29, 1'b0, 1'b0);
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL badstop_status: got %h want %h", act, exp);
      end
      send_frame(8'h29, 1'b0, 1'b1);
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL badstop_next: got %h want %h", act, exp);
      end
   endtask

   task automatic test_parity();
      logic [31:0] act, exp;
      send_frame(8'h1C, 1'b1, 1'b1);
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL parity_status: got %h want %h", act, exp);
      end
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL parity_data: got %h want %h", act, exp);
      end
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL parity_cleared: got %h want %h", act, exp);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] act, exp;
      send_bits(8'h55, 1'b0, 1'b1, 4);
      repeat (1100) @(posedge clk);
      send_frame(8'h29, 1'b0, 1'b1);
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL timeout_status: got %h want %h", act, exp);
      end
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL timeout_data: got %h want %h", act, exp);
      end
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL timeout_single: got %h want %h", act, exp);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] act, exp;
      send_frame(8'h42, 1'b0, 1'b1);
      send_bits(8'hA5, 1'b0, 1'b1, 5);
      #3;
      apply_reset();
      #1;
      tests_run++;
      if ({irq, overflow, cpu_rd_data} !== 34'd0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got irq=%b ovf=%b data=%h want 0",
                  irq, overflow, cpu_rd_data);
      end
      @(negedge clk);
      reset = 1'b0;
      do_status(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL midreset_status: got %h want %h", act, exp);
      end
      send_frame(8'h1C, 1'b0, 1'b1);
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL midreset_data: got %h want %h", act, exp);
      end
      // A read of an empty FIFO must not move the pointers: the next byte
      // must still come out in order.
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL empty_read: got %h want %h", act, exp);
      end
      send_frame(8'h5A, 1'b0, 1'b1);
      do_data(act, exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL empty_nomove: got %h want %h", act, exp);
      end
   endtask

   task automatic test_decode();
      logic [31:0] act, addr;
      logic hit;
      send_frame(8'h77, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         addr = $urandom;
         if (i == 0) addr = A_STATUS + 32'd8;
         if (addr == A_STATUS || addr == A_DATA) addr = 32'd0;
         read_reg(addr, act, hit);
         tests_run++;
         if (act !== 32'd0 || hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL decode_miss: addr %h got data=%h hit=%b want 0/0", addr, act, hit);
         end
      end
      @(negedge clk);
      cpu_addr = A_DATA;
      #1;
      tests_run++;
      if (cpu_rd_hit !== 1'b0 || cpu_rd_data !== 32'd0) begin
         tests_failed++;
         $display("FAIL decode_noen: got hit=%b data=%h want 0/0", cpu_rd_hit, cpu_rd_data);
      end
      cpu_addr = 32'd0;
   endtask

   task automatic test_random();
      logic [31:0] act, exp;
      int op, kind;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 3);
         if (op <= 1) begin
            kind = $urandom_range(0, 7);
            send_frame(8'($urandom), (kind == 1), (kind != 0));
         end else if (op == 2) begin
            do_status(act, exp);
            tests_run++;
            if (act !== exp) begin
               tests_failed++;
               $display("FAIL rand_status%0d: got %h want %h", i, act, exp);
            end
         end else begin
            do_data(act, exp);
            tests_run++;
            if (act !== exp) begin
               tests_failed++;
               $display("FAIL rand_data%0d: got %h want %h", i, act, exp);
            end
         end
         #1;
         tests_run++;
         if (irq !== (model_q.size() != 0) || overflow !== model_ovf) begin
            tests_failed++;
            $display("FAIL rand_pins%0d: got irq=%b ovf=%b want irq=%b ovf=%b",
                     i, irq, overflow, (model_q.size() != 0), model_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_bad_stop();
      test_parity();
      test_timeout();
      test_reset_midframe();
      test_decode();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
